// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, FSM states and drain-length helper for the systolic sequencer
package systolic_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_DW = 16;
  localparam int DEF_KMAX = 16;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  function automatic int DRAIN_CYC(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: valid+data delay line that zeroes invalid slots; DEPTH=0 is a gated pass-through
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data
);
  if (DEPTH == 0) begin : g_pass
    assign out_data = in_vld ? in_data : '0;
  end else begin : g_shift
    logic [DEPTH-1:0] vld;
    logic [DW-1:0] dat [DEPTH];
    // shift valid and zero-masked data one stage per cycle; flush drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
        vld <= '0;
        for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
      end else begin
        vld[0] <= in_vld;
        dat[0] <= in_vld ? in_data : '0;
        for (int k = 1; k < DEPTH; k++) begin
          vld[k] <= vld[k-1];
          dat[k] <= dat[k-1];
        end
      end
    end
    assign out_data = vld[DEPTH-1] ? dat[DEPTH-1] : '0;
  end
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job FSM, operand fetch and diagonal skew for an N x N systolic multiply array
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int DW = DEF_DW,
  parameter int KMAX = DEF_KMAX,
  parameter int KW = $clog2(KMAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [KW-1:0]           k_len,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(KMAX)-1:0] op_addr,
  output logic                    op_rd,
  input  logic [N*DW-1:0]         a_col,
  input  logic [N*DW-1:0]         b_row,
  output logic [N*DW-1:0]         west_bus,
  output logic [N*DW-1:0]         north_bus,
  output logic                    arr_rst
);
  localparam int AW = $clog2(KMAX);
  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC(N) - 1);
  state_t state;
  logic [KW-1:0] k_q;
  logic [CW-1:0] cnt;
  logic rd_q;
  logic accept;
  logic kill;
  assign accept = state == IDLE && start && k_len != '0;
  assign kill = abort && state != IDLE;
  // busy covers the accepting cycle itself, hence the combinational accept term
  assign busy = rst_n && (state != IDLE || accept);
  // sequencer: clear, stream K addresses, wait for the wavefront to cross the array, report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k_q <= '0;
      cnt <= '0;
      op_addr <= '0;
      op_rd <= 1'b0;
      rd_q <= 1'b0;
      arr_rst <= 1'b1;
      done <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      cnt <= '0;
      op_addr <= '0;
      op_rd <= 1'b0;
      rd_q <= 1'b0;
      arr_rst <= 1'b1;
      done <= 1'b0;
    end else begin
      arr_rst <= 1'b0;
      done <= 1'b0;
      rd_q <= op_rd;
      case (state)
        IDLE: if (accept) begin
          state <= CLEAR;
          k_q <= k_len > KW'(KMAX) ? KW'(KMAX) : k_len;
          arr_rst <= 1'b1;
        end
        CLEAR: begin
          state <= FEED;
          op_rd <= 1'b1;
          op_addr <= '0;
        end
        FEED: if (KW'(op_addr) == k_q - KW'(1)) begin
          state <= DRAIN;
          op_rd <= 1'b0;
          op_addr <= '0;
          cnt <= DRAIN_LOAD;
        end else begin
          op_addr <= op_addr + AW'(1);
        end
        DRAIN: if (cnt == '0) begin
          state <= DONE;
          done <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i), .DW(DW)) u_west (
      .clk(clk), .rst_n(rst_n), .flush(kill), .in_vld(rd_q),
      .in_data(a_col[i*DW +: DW]), .out_data(west_bus[i*DW +: DW])
    );
    skew_line #(.DEPTH(i), .DW(DW)) u_north (
      .clk(clk), .rst_n(rst_n), .flush(kill), .in_vld(rd_q),
      .in_data(b_row[i*DW +: DW]), .out_data(north_bus[i*DW +: DW])
    );
  end
endmodule
